wb_arbiter_n: RTL and testbench

Parametrised N-master to 1-slave Wishbone (B3 classic) arbiter. It generalises the fixed two-master instruction/data pairing of the CPU core to N masters: CPU instruction and data ports plus DMA and debug ports. All masters share a single memory or peripheral slave port.
The arbiter offers round-robin or fixed-priority policy and locks the grant for the full cycle (cyc). An optional watchdog aborts hung transfers.

---
 rtl/wb_arb_pkg.sv | 22 ++
 rtl/wb_arb_pick.sv | 30 +++
 rtl/wb_arbiter_n.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter_n.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared state type, policy constants and helpers for the Wishbone N-master arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int MAX_MASTERS = 8;

    function automatic logic [2:0] oh2idx(input logic [MAX_MASTERS-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_MASTERS; i++)
            if (oh[i]) idx = idx | 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Rotating-pointer priority picker: first requester at or above ptr (wrapping), or
// lowest index when rr=0. Purely combinational, one-hot result.
module wb_arb_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          rr,
    output logic [N-1:0]  win
);

    logic [N-1:0] upper;
    logic [N-1:0] pool;

    // Requesters at/above the pointer win first; if none, wrap to the full set.
    always_comb begin
        upper = '0;
        for (int i = 0; i < N; i++)
            upper[i] = req[i] && (!rr || i >= int'(ptr));
        pool = (|upper) ? upper : req;
        win  = '0;
        for (int i = N - 1; i >= 0; i--)
            if (pool[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
    end

endmodule

// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone B3 classic arbiter; grant is locked for the whole cyc.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that flags m_err and aborts stalled transfers.
module wb_arbiter_n
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int RR             = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_MASTERS-1:0]    m_cyc,
    input  logic [N_MASTERS-1:0]    m_stb,
    input  logic [N_MASTERS-1:0]    m_we,
    input  logic [N_MASTERS*DW/8-1:0] m_sel,
    input  logic [N_MASTERS*AW-1:0] m_adr,
    input  logic [N_MASTERS*DW-1:0] m_dat_w,
    output logic [DW-1:0]           m_dat_r,
    output logic [N_MASTERS-1:0]    m_ack,
    output logic [N_MASTERS-1:0]    m_err,
    output logic                    s_cyc,
    output logic                    s_stb,
    output logic                    s_we,
    output logic [DW/8-1:0]         s_sel,
    output logic [AW-1:0]           s_adr,
    output logic [DW-1:0]           s_dat_w,
    input  logic [DW-1:0]           s_dat_r,
    input  logic                    s_ack,
    output logic [N_MASTERS-1:0]    gnt
);

    localparam int SW = DW / 8;
    localparam int PW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    arb_state_t           state, state_n;
    logic [N_MASTERS-1:0] gnt_n, win;
    logic [PW-1:0]        rr_ptr, rr_ptr_n, win_nxt;
    logic [2:0]           win_idx;
    logic                 busy, cyc_g;

    wb_arb_pick #(.N(N_MASTERS), .PW(PW)) u_pick (
        .req (m_cyc),
        .ptr (rr_ptr),
        .rr  (RR == ARB_RR),
        .win (win)
    );

    assign busy  = (state == GRANT);
    assign cyc_g = |(m_cyc & gnt);

    always_comb begin
        win_idx = oh2idx(MAX_MASTERS'(win));
        win_nxt = (int'(win_idx) == N_MASTERS - 1) ? '0 : PW'(int'(win_idx) + 1);
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_cnt;
    logic          timeout;

    // Fires on the last tolerated stall cycle; the abort takes effect next cycle.
    assign timeout = busy && cyc_g && s_stb && !s_ack && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
    assign m_err   = timeout ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (!busy || state_n != GRANT || s_ack)
            wd_cnt <= '0;
        else if (s_stb)
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign m_err = '0;
`endif

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        rr_ptr_n = rr_ptr;
        case (state)
            IDLE: begin
                if (|m_cyc) begin
                    state_n = GRANT;
                    gnt_n   = win;
                    if (RR == ARB_RR) rr_ptr_n = win_nxt;
                end
            end
            GRANT: begin
                if (!cyc_g) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_n = ABORT;
                end
            end
            ABORT: begin
                if (!cyc_g) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            gnt    <= gnt_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    // Slave side follows the granted master only while in GRANT.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (busy && gnt[i]) begin
                s_cyc   = m_cyc[i];
                s_stb   = m_stb[i];
                s_we    = m_we[i];
                s_sel   = m_sel[i*SW +: SW];
                s_adr   = m_adr[i*AW +: AW];
                s_dat_w = m_dat_w[i*DW +: DW];
            end
    end

    assign m_ack   = busy ? (gnt & {N_MASTERS{s_ack}}) : '0;
    assign m_dat_r = s_dat_r;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Randomised + directed bench for wb_arbiter_n: one round-robin and one fixed-priority
// instance share the masters; a per-instance reference model feeds a grant scoreboard.
module tb_wb_arbiter_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*SW-1:0] m_sel;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [DW-1:0]   s_dat_r;
    logic            s_ack;

    logic [DW-1:0] m_dat_r_0, m_dat_r_1, s_dat_w_0, s_dat_w_1;
    logic [N-1:0]  m_ack_0, m_ack_1, m_err_0, m_err_1, gnt_0, gnt_1;
    logic          s_cyc_0, s_stb_0, s_we_0, s_cyc_1, s_stb_1, s_we_1;
    logic [SW-1:0] s_sel_0, s_sel_1;
    logic [AW-1:0] s_adr_0, s_adr_1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_arbiter_n #(.N_MASTERS(N), .AW(AW), .DW(DW), .RR(1), .TIMEOUT_CYCLES(TO)) u_rr (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r_0), .m_ack(m_ack_0), .m_err(m_err_0),
        .s_cyc(s_cyc_0), .s_stb(s_stb_0), .s_we(s_we_0), .s_sel(s_sel_0), .s_adr(s_adr_0),
        .s_dat_w(s_dat_w_0), .s_dat_r(s_dat_r), .s_ack(s_ack), .gnt(gnt_0)
    );

    wb_arbiter_n #(.N_MASTERS(N), .AW(AW), .DW(DW), .RR(0), .TIMEOUT_CYCLES(TO)) u_fx (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_sel(m_sel),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r_1), .m_ack(m_ack_1), .m_err(m_err_1),
        .s_cyc(s_cyc_1), .s_stb(s_stb_1), .s_we(s_we_1), .s_sel(s_sel_1), .s_adr(s_adr_1),
        .s_dat_w(s_dat_w_1), .s_dat_r(s_dat_r), .s_ack(s_ack), .gnt(gnt_1)
    );

    // Reference model: owner = granted master (-1 none), next-favoured pointer, stall count.
    int owner[2] = '{-1, -1};
    int ptr[2]   = '{0, 0};
    int wd[2]    = '{0, 0};
    bit aborted[2] = '{1'b0, 1'b0};
    int q0[$], q1[$];
    int gseq0[$], gseq1[$];
    logic [N-1:0] prev_gnt[2] = '{'0, '0};

    function automatic int ref_pick(input logic [N-1:0] req, input int base);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (base + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic bit err_now(input int d);
`ifdef WB_ARB_TIMEOUT_EN
        int o;
        o = owner[d];
        return (o >= 0) && !aborted[d] && m_cyc[o] && m_stb[o] && !s_ack && (wd[d] == TO - 1);
`else
        return (d < 0);
`endif
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            if (rst) begin
                owner[d] = -1; ptr[d] = 0; wd[d] = 0; aborted[d] = 1'b0;
            end else if (owner[d] < 0) begin
                if (|m_cyc) begin
                    w = ref_pick(m_cyc, (d == 0) ? ptr[d] : 0);
                    owner[d] = w;
                    ptr[d]   = (w + 1) % N;
                    if (d == 0) q0.push_back(w); else q1.push_back(w);
                end
            end else if (!m_cyc[owner[d]]) begin
                owner[d] = -1; wd[d] = 0; aborted[d] = 1'b0;
            end else if (!aborted[d]) begin
                if (err_now(d)) begin aborted[d] = 1'b1; wd[d] = 0; end
                else if (s_ack) wd[d] = 0;
                else if (m_stb[owner[d]]) wd[d] = wd[d] + 1;
            end
        end
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input logic [N-1:0] gnt, input logic sc, input logic ss,
                             input logic swe, input logic [SW-1:0] ssel, input logic [AW-1:0] sadr,
                             input logic [DW-1:0] sdw, input logic [N-1:0] ack,
                             input logic [N-1:0] err, input logic [DW-1:0] mdr);
        int o, w, gi;
        bit busy;
        logic [N-1:0] eg, ew;
        o = owner[d];
        busy = (o >= 0) && !aborted[d];
        eg = '0;
        if (o >= 0) eg[o] = 1'b1;
        chk("gnt", d, gnt, eg);
        chk("s_cyc", d, sc, busy && m_cyc[o]);
        chk("s_stb", d, ss, busy && m_stb[o]);
        chk("s_we", d, swe, busy && m_we[o]);
        chk("s_sel", d, ssel, busy ? m_sel[o*SW +: SW] : '0);
        chk("s_adr", d, sadr, busy ? m_adr[o*AW +: AW] : '0);
        chk("s_dat_w", d, sdw, busy ? m_dat_w[o*DW +: DW] : '0);
        chk("m_ack", d, ack, (busy && s_ack) ? eg : '0);
        chk("m_err", d, err, err_now(d) ? eg : '0);
        chk("m_dat_r", d, mdr, s_dat_r);
        if (gnt != '0 && prev_gnt[d] == '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (gnt[i]) gi = i;
            if (d == 0) gseq0.push_back(gi); else gseq1.push_back(gi);
            if ((d == 0 ? q0.size() : q1.size()) == 0) chk("sb_grant", d, gnt, '0);
            else begin
                w = (d == 0) ? q0.pop_front() : q1.pop_front();
                ew = '0; ew[w] = 1'b1;
                chk("sb_grant", d, gnt, ew);
            end
        end
        prev_gnt[d] = gnt;
    endtask

    always @(negedge clk) begin
        check_dut(0, gnt_0, s_cyc_0, s_stb_0, s_we_0, s_sel_0, s_adr_0, s_dat_w_0, m_ack_0, m_err_0, m_dat_r_0);
        check_dut(1, gnt_1, s_cyc_1, s_stb_1, s_we_1, s_sel_1, s_adr_1, s_dat_w_1, m_ack_1, m_err_1, m_dat_r_1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_adr[i*AW +: AW] = adr; m_dat_w[i*DW +: DW] = dat; m_sel[i*SW +: SW] = sel;
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0; m_we = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; idle_all(); s_ack = 1'b0; s_dat_r = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Masters re-request one cycle after each ack seen on instance d; slave always acks.
    task automatic react(input int d, input logic [N-1:0] act, input int ncyc);
        logic [N-1:0] ack_prev;
        ack_prev = '0;
        if (d == 0) gseq0.delete(); else gseq1.delete();
        s_ack = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            for (int i = 0; i < N; i++) begin
                bit on;
                on = act[i] && !(m_cyc[i] && ack_prev[i]);
                set_m(i, on, on, 1'b0, AW'($urandom), DW'($urandom), '1);
            end
            @(negedge clk);
            ack_prev = (d == 0) ? m_ack_0 : m_ack_1;
            tick();
        end
        idle_all(); s_ack = 1'b0;
        repeat (3) tick();
    endtask

    int hold[N], gap[N];
    int acks, err_at;

    initial begin
        // Reset with every master requesting: nothing may be granted or acked.
        rst = 1'b1; m_cyc = '1; m_stb = '1; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
        s_ack = 1'b1; s_dat_r = 32'h1234_5678;
        @(negedge clk);
        chk("rst_gnt", 0, gnt_0, '0);
        chk("rst_scyc", 0, s_cyc_0, 1'b0);
        chk("rst_ack", 0, m_ack_0, '0);
        chk("rst_err", 0, m_err_0, '0);
        do_reset();

        // Single read by master 1.
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'hf);
        @(negedge clk);
        chk("t1_gnt_lat", 0, gnt_0, '0);
        tick();
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("t1_gnt", 0, gnt_0, 4'b0010);
        chk("t1_gnt_fx", 1, gnt_1, 4'b0010);
        chk("t1_adr", 0, s_adr_0, 32'h100);
        chk("t1_we", 0, s_we_0, 1'b0);
        chk("t1_ack", 0, m_ack_0, 4'b0010);
        chk("t1_rdata", 0, m_dat_r_0, 32'hDEAD_BEEF);
        tick();
        idle_all(); s_ack = 1'b0;
        repeat (2) tick();

        // Two masters re-requesting: RR alternates, fixed always picks 0.
        do_reset();
        react(0, 4'b0011, 14);
        chk("t2_rr_count", 0, gseq0.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t2_rr_order%0d", k), 0, (k < gseq0.size()) ? gseq0[k] : 99, k % 2);
        do_reset();
        react(1, 4'b0011, 14);
        chk("t2_fx_count", 1, gseq1.size() >= 3, 1'b1);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_fx_order%0d", k), 1, (k < gseq1.size()) ? gseq1[k] : 99, 0);

        // Burst lock: master 0 holds cyc for 4 acks while master 1 waits.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b1, 32'hA0, 32'h55, 4'hf);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'hB0, 32'h66, 4'hf);
        s_ack = 1'b1; acks = 0;
        for (int c = 0; c < 20 && acks < 4; c++) begin
            @(negedge clk);
            chk("t3_ack1", 0, m_ack_0[1], 1'b0);
            if (gnt_0 != '0) chk("t3_locked", 0, gnt_0, 4'b0001);
            if (m_ack_0[0]) acks++;
            if (acks < 4) tick();
        end
        chk("t3_acks", 0, acks, 4);
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        @(negedge clk);
        chk("t3_rel_gnt", 0, gnt_0, 4'b0001);
        chk("t3_rel_scyc", 0, s_cyc_0, 1'b0);
        tick();
        @(negedge clk);
        chk("t3_dead", 0, gnt_0, '0);
        tick();
        @(negedge clk);
        chk("t3_next", 0, gnt_0, 4'b0010);
        tick();
        idle_all(); s_ack = 1'b0;
        repeat (2) tick();

        // Four masters continuously requesting: pointer wraps 3 -> 0.
        do_reset();
        react(0, 4'b1111, 18);
        for (int k = 0; k < 5; k++)
            chk($sformatf("t4_wrap%0d", k), 0, (k < gseq0.size()) ? gseq0[k] : 99, k % 4);

        // Reset in GRANT with stb pending; late ack ignored; pointer back to 0.
        do_reset();
        set_m(2, 1'b1, 1'b1, 1'b0, 32'hC0, 32'h0, 4'hf);
        tick();
        @(negedge clk);
        chk("t5_pre_gnt", 0, gnt_0, 4'b0100);
        tick();
        rst = 1'b1;
        set_m(3, 1'b1, 1'b1, 1'b0, 32'hD0, 32'h0, 4'hf);
        tick();
        rst = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        chk("t5_gnt", 0, gnt_0, '0);
        chk("t5_scyc", 0, s_cyc_0, 1'b0);
        chk("t5_late_ack", 0, m_ack_0, '0);
        tick();
        s_ack = 1'b0;
        @(negedge clk);
        chk("t5_regrant", 0, gnt_0, 4'b0100);
        tick();
        idle_all();
        repeat (2) tick();

        // Slave never acks.
        do_reset();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'hE0, 32'h0, 4'hf);
        err_at = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
            if (m_err_0 != '0 && err_at < 0) err_at = c;
            if (c == 9) begin
                chk("t6_abort_scyc", 0, s_cyc_0, 1'b0);
                chk("t6_abort_gnt", 0, gnt_0, 4'b0001);
            end
`else
            if (c >= 1) chk("t6_hold_scyc", 0, s_cyc_0, 1'b1);
            chk("t6_no_err", 0, m_err_0, '0);
`endif
            tick();
        end
`ifdef WB_ARB_TIMEOUT_EN
        chk("t6_err_cycle", 0, err_at, 8);
`endif
        idle_all();
        repeat (2) tick();
        @(negedge clk);
        chk("t6_released", 0, gnt_0, '0);
        tick();

        // Random traffic: bursts, aborts, stray strobes, late acks, occasional reset.
        do_reset();
        for (int i = 0; i < N; i++) begin hold[i] = 0; gap[i] = 0; end
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            for (int i = 0; i < N; i++) begin
                if (hold[i] > 0) begin
                    hold[i]--;
                    if (hold[i] == 0) begin
                        m_cyc[i] = 1'b0;
                        m_stb[i] = ($urandom_range(0, 7) == 0);
                        gap[i] = $urandom_range(1, 3);
                    end else m_stb[i] = ($urandom_range(0, 4) != 0);
                end else if (gap[i] > 0) begin
                    gap[i]--;
                    m_stb[i] = ($urandom_range(0, 7) == 0);
                end else if ($urandom_range(0, 2) == 0) begin
                    hold[i] = $urandom_range(1, 8);
                    set_m(i, 1'b1, 1'b1, 1'($urandom), AW'($urandom), DW'($urandom), SW'($urandom));
                end else m_stb[i] = 1'b0;
            end
            s_ack = ($urandom_range(0, 2) != 0);
            s_dat_r = DW'($urandom);
            tick();
        end
        rst = 1'b0; idle_all(); s_ack = 1'b0;
        repeat (4) tick();
        chk("sb_drain", 0, q0.size(), 0);
        chk("sb_drain", 1, q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
